// File: rtl/reg_file.sv
// reg_file: 32 x WIDTH register file with one synchronous write port and two
// combinational read ports. Register 31 (XZR) is hard-wired to zero. Read
// ports are bit-sliced 32:1 mux trees built from 2:1 / 4:1 / 8:1 mux cells,
// and write enables come from a RegWrite-gated 5:32 decoder. A same-cycle
// write-through bypass covers the WB/ID overlap.

// 2:1 mux leaf cell, one bit wide.
module reg_file_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// 4:1 mux cell built from three 2:1 cells.
module reg_file_mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  logic lo_y;
  logic hi_y;

  reg_file_mux2 u_lo  (.d0(d[0]), .d1(d[1]), .sel(sel[0]), .y(lo_y));
  reg_file_mux2 u_hi  (.d0(d[2]), .d1(d[3]), .sel(sel[0]), .y(hi_y));
  reg_file_mux2 u_out (.d0(lo_y), .d1(hi_y), .sel(sel[1]), .y(y));
endmodule

// 8:1 mux cell built from two 4:1 cells and a 2:1 cell.
module reg_file_mux8 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);
  logic lo_y;
  logic hi_y;

  reg_file_mux4 u_lo  (.d(d[3:0]), .sel(sel[1:0]), .y(lo_y));
  reg_file_mux4 u_hi  (.d(d[7:4]), .sel(sel[1:0]), .y(hi_y));
  reg_file_mux2 u_out (.d0(lo_y), .d1(hi_y), .sel(sel[2]), .y(y));
endmodule

// 32:1 mux slice: four 8:1 cells on the low address bits feed a 4:1 cell
// steered by the two high address bits.
module reg_file_mux32 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  logic [3:0] bank_y;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      reg_file_mux8 u_mux8 (
        .d   (d[gi*8 +: 8]),
        .sel (sel[2:0]),
        .y   (bank_y[gi])
      );
    end
  endgenerate

  reg_file_mux4 u_top (.d(bank_y), .sel(sel[4:3]), .y(y));
endmodule

// 5:32 decoder gated by an enable, built from 2:4 and 3:8 predecoders.
module reg_file_dec5to32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] dec
);
  logic [3:0] hi_dec;
  logic [7:0] lo_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hi
      // enable is folded into the high predecoder so every output is gated
      assign hi_dec[gi] = en & (addr[4:3] == 2'(gi));
    end
    for (gi = 0; gi < 8; gi++) begin : g_lo
      assign lo_dec[gi] = (addr[2:0] == 3'(gi));
    end
    for (gi = 0; gi < 32; gi++) begin : g_out
      assign dec[gi] = hi_dec[gi / 8] & lo_dec[gi % 8];
    end
  endgenerate
endmodule

// Top-level register file.
module reg_file #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // All register rows flattened into one bus; row r occupies [r*WIDTH +: WIDTH].
  logic [NREGS*WIDTH-1:0] row_bus;
  logic [NREGS-1:0]       we_dec;
  logic [WIDTH-1:0]       mux_rd1;
  logic [WIDTH-1:0]       mux_rd2;
  logic                   wr_active;
  logic                   bypass1;
  logic                   bypass2;

  // Per-register write enables. A write to XZR still decodes, but that row
  // has no flops, so it is discarded.
  reg_file_dec5to32 u_dec (
    .en   (RegWrite),
    .addr (WriteRegister),
    .dec  (we_dec)
  );

  genvar gi, gj;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_row
      if (gi == ZERO_REG) begin : g_zero
        // XZR holds no state; its decoded enable is intentionally unused.
        logic unused_zero_we;
        assign unused_zero_we       = we_dec[gi];
        assign row_bus[gi*WIDTH +: WIDTH] = '0;
      end else begin : g_flop
        logic [WIDTH-1:0] q_reg;

        // Enabled D-flop bank; reset takes priority over a same-edge write.
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= '0;
          end else if (we_dec[gi]) begin
            q_reg <= WriteData;
          end
        end

        assign row_bus[gi*WIDTH +: WIDTH] = q_reg;
      end
    end

    // Bit-sliced read trees: each data bit gets its own pair of 32:1 muxes
    // fed by that bit's column across all rows.
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      logic [NREGS-1:0] col;

      for (gj = 0; gj < NREGS; gj++) begin : g_col
        assign col[gj] = row_bus[gj*WIDTH + gi];
      end

      reg_file_mux32 u_rd1 (.d(col), .sel(ReadRegister1), .y(mux_rd1[gi]));
      reg_file_mux32 u_rd2 (.d(col), .sel(ReadRegister2), .y(mux_rd2[gi]));
    end
  endgenerate

  // A write counts for bypass only if it will actually land on this edge.
  assign wr_active = RegWrite & ~reset & (WriteRegister != 5'(ZERO_REG));
  assign bypass1   = wr_active & (ReadRegister1 == WriteRegister);
  assign bypass2   = wr_active & (ReadRegister2 == WriteRegister);

  // Write-through: each port independently forwards the in-flight write data.
  assign ReadData1 = bypass1 ? WriteData : mux_rd1;
  assign ReadData2 = bypass2 ? WriteData : mux_rd2;

endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file against an array-based model.
module tb_reg_file;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [4:0]   ReadRegister1;
  logic [4:0]   ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  logic [W-1:0] model [32];
  int n_compared   = 0;
  int n_mismatched = 0;
  int n_txn        = 0;

  reg_file #(.WIDTH(W), .NREGS(32), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What a read should show given the inputs currently driven.
  function automatic logic [W-1:0] expect_read(input logic [4:0] ra);
    if (!reset && RegWrite && WriteRegister != 5'd31 && ra == WriteRegister)
      return WriteData;
    if (ra == 5'd31)
      return '0;
    return model[ra];
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One transaction: drive on the falling edge, check reads just after,
  // then let the rising edge commit and update the model.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [W-1:0] wd, input logic [4:0] ra1,
                       input logic [4:0] ra2, input bit chk);
    @(negedge clk);
    reset         = rst;
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = ra1;
    ReadRegister2 = ra2;
    #1;
    if (chk) begin
      check_val($sformatf("rd1[%0d]", ra1), ReadData1, expect_read(ra1));
      check_val($sformatf("rd2[%0d]", ra2), ReadData2, expect_read(ra2));
    end
    n_txn++;
    $display("txn %0d rst=%0b we=%0b wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
             n_txn, rst, we, wa, wd, ra1, ReadData1, ra2, ReadData2);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 31; r++) model[r] = '0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] base;
    base = 64'h0123_4567_89AB_0000;
    for (int r = 0; r < 32; r++) model[r] = '0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;

    // 1. Reset, then every index on both ports reads zero
    cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b0, 5'($urandom_range(0, 31)), rand64(), 5'(i), 5'(31 - i), 1'b1);

    // 2. Write base+i everywhere, then read back with crossed addresses
    for (int i = 0; i < 31; i++)
      cycle(1'b0, 1'b1, 5'(i), base + W'(i), 5'($urandom_range(0, 31)),
            5'(i), 1'b1);
    for (int i = 0; i < 31; i++)
      cycle(1'b0, 1'b0, 5'(i), rand64(), 5'(i), 5'(30 - i), 1'b1);

    // 3. XZR write is discarded
    cycle(1'b0, 1'b1, 5'd31, {W{1'b1}}, 5'd31, 5'd31, 1'b1);
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'd31, 1'b1);

    // 4. Bypass on both ports
    cycle(1'b0, 1'b1, 5'd5, 64'hA, 5'd0, 5'd1, 1'b1);
    cycle(1'b0, 1'b0, 5'd5, 64'hB, 5'd5, 5'd5, 1'b1);
    check_val("t4_hold_a", ReadData1, 64'hA);
    cycle(1'b0, 1'b1, 5'd5, 64'hB, 5'd5, 5'd5, 1'b1);
    cycle(1'b0, 1'b0, 5'd5, 64'hC, 5'd5, 5'd5, 1'b1);
    #1;
    check_val("t4_after_b", ReadData2, 64'hB);

    // 5. Reset beats a same-edge write; reads show old contents meanwhile
    cycle(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b1);
    cycle(1'b1, 1'b1, 5'd7, 64'h77, 5'd7, 5'd7, 1'b1);
    cycle(1'b0, 1'b0, 5'd7, 64'h77, 5'd7, 5'd30, 1'b1);
    #1;
    check_val("t5_reg7_zero", ReadData1, '0);

    // 6. Enable gating: fill randomly, then sweep with RegWrite low
    for (int i = 0; i < 31; i++)
      cycle(1'b0, 1'b1, 5'(i), rand64(), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'b1);
    for (int i = 0; i < 31; i++)
      cycle(1'b0, 1'b0, 5'(i), rand64(), 5'(i), 5'($urandom_range(0, 31)), 1'b1);
    for (int i = 0; i < 31; i++)
      cycle(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(30 - i), 1'b1);

    // Random mix, with reads biased toward the write address to hit bypass
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 39) == 0), 1'($urandom), wa, rand64(),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
